// File: rtl/window_mac_engine.sv
// window_mac_engine: sequential signed dot product of one window against one
// kernel. One element pair is read and accumulated per clock, the finished
// sum is held on a valid/ready result port until the consumer takes it.
//
// Optional feature: define WINDOW_MAC_RELU_EN to clamp negative final sums
// to zero before they are registered into result. Default build passes the
// raw signed sum.
//
// Result handshake: result_valid is high only in DONE and result is stable
// while result_valid is high; the transfer happens on a rising edge where
// result_valid && result_ready are both high. There is no combinational path
// from result_ready to result_valid.

module window_mac_engine #(
  parameter int WINDOW_ELEMNT_SIZE = 8,
  parameter int WINDOW_REG_SIZE    = 9,
  parameter int ADDR_SIZE          = 4,
  parameter int ACC_SIZE           = 20
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          start,
  output logic                          busy,
  output logic [ADDR_SIZE-1:0]          rd_addr,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] rd_data,
  output logic [ADDR_SIZE-1:0]          w_addr,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] w_data,
  output logic [ACC_SIZE-1:0]           result,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PROD_SIZE = 2 * WINDOW_ELEMNT_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(WINDOW_REG_SIZE - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_SIZE-1:0]   index_q;
  logic [ACC_SIZE-1:0]    acc_q;
  logic [ACC_SIZE-1:0]    result_q;

  // control strobes produced by the FSM for the datapath
  logic                   clear_acc;
  logic                   do_mac;
  logic                   load_result;

  logic                   handshake;
  logic                   last_elem;
  logic signed [PROD_SIZE-1:0] product;
  logic signed [ACC_SIZE-1:0]  product_ext;
  logic [ACC_SIZE-1:0]    sum_next;
  logic [ACC_SIZE-1:0]    final_value;

  assign handshake = (state_q == DONE) && result_ready;
  assign last_elem = (index_q == LAST_IDX);

  // signed x signed product, sign-extended (or wrapped) to accumulator width
  assign product     = $signed(rd_data) * $signed(w_data);
  assign product_ext = ACC_SIZE'(product);
  assign sum_next    = acc_q + product_ext;

`ifdef WINDOW_MAC_RELU_EN
  // negative sums are clamped to zero before reaching result
  assign final_value = sum_next[ACC_SIZE-1] ? '0 : sum_next;
`else
  assign final_value = sum_next;
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and control strobes
  always_comb begin
    state_d     = state_q;
    clear_acc   = 1'b0;
    do_mac      = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_acc = 1'b1;
          state_d   = MAC;
        end
      end
      MAC: begin
        do_mac = 1'b1;
        if (last_elem) begin
          load_result = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // start only counts together with the handshake
        if (handshake) begin
          if (start) begin
            clear_acc = 1'b1;
            state_d   = MAC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // element index: cleared on a new request, advanced once per MAC cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      index_q <= '0;
    end else if (clear_acc) begin
      index_q <= '0;
    end else if (do_mac) begin
      index_q <= index_q + 1'b1;
    end
  end

  // accumulator: wraps modulo 2^ACC_SIZE, never saturates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else if (clear_acc) begin
      acc_q <= '0;
    end else if (do_mac) begin
      acc_q <= sum_next;
    end
  end

  // result register: loaded with the last partial sum, held otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
    end else if (load_result) begin
      result_q <= final_value;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign rd_addr      = (state_q == MAC) ? index_q : '0;
  assign w_addr       = rd_addr;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_window_mac_engine.sv
// Directed bench for window_mac_engine with hand-computed dot products.
// Window and weight memories are modelled as combinational lookups.

module tb_window_mac_engine;

  localparam int W   = 8;
  localparam int N   = 9;
  localparam int AW  = 4;
  localparam int ACC = 20;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic           start = 1'b0;
  logic           busy;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   rd_data;
  logic [AW-1:0]  w_addr;
  logic [W-1:0]   w_data;
  logic [ACC-1:0] result;
  logic           result_valid;
  logic           result_ready = 1'b0;
  logic [1:0]     dbg_state;

  logic [W-1:0] win_mem [0:N-1];
  logic [W-1:0] wgt_mem [0:N-1];

  assign rd_data = (int'(rd_addr) < N) ? win_mem[rd_addr] : '0;
  assign w_data  = (int'(w_addr) < N) ? wgt_mem[w_addr] : '0;

  window_mac_engine #(
    .WINDOW_ELEMNT_SIZE(W),
    .WINDOW_REG_SIZE(N),
    .ADDR_SIZE(AW),
    .ACC_SIZE(ACC)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .start(start),
    .busy(busy),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .w_addr(w_addr),
    .w_data(w_data),
    .result(result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected registered value for a given signed sum
  function automatic logic [ACC-1:0] exp_out(input int sum);
    logic [ACC-1:0] v;
    v = ACC'(sum);
`ifdef WINDOW_MAC_RELU_EN
    if (sum < 0) v = '0;
`endif
    return v;
  endfunction

  task automatic fill(input logic [W-1:0] wv, input logic [W-1:0] kv);
    for (int i = 0; i < N; i++) begin
      win_mem[i] = wv;
      wgt_mem[i] = kv;
    end
  endtask

  // Called at a negedge: raises start for the coming edge (cycle N), then
  // walks cycles N+1..N+10 checking busy, addresses and result timing.
  // Returns at the negedge of cycle N+10 with the DUT in DONE.
  task automatic run_dot(input string tag, input logic [ACC-1:0] exp);
    start = 1'b1;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge i_clk);
      if (k == 1) begin
        start        = 1'b0;
        result_ready = 1'b0;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (k <= N) begin
        check({tag, "_valid_lo"}, 32'(result_valid), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'(k - 1));
        check({tag, "_w_addr"}, 32'(w_addr), 32'(k - 1));
      end else begin
        check({tag, "_valid_hi"}, 32'(result_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp));
      end
    end
  endtask

  // Called in DONE at a negedge: accept the result and confirm IDLE.
  task automatic accept(input string tag, input logic [ACC-1:0] held);
    result_ready = 1'b1;
    @(negedge i_clk);
    result_ready = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_idle_result"}, 32'(result), 32'(held));
    check({tag, "_idle_addr"}, 32'(rd_addr), 32'd0);
  endtask

  initial begin
    logic [ACC-1:0] e;
    fill(8'd1, 8'd1);

    // reset state
    repeat (3) @(negedge i_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // all ones -> 9
    e = exp_out(9);
    run_dot("ones", e);
    accept("ones", e);

    // -128 x -128 -> 147456
    fill(8'h80, 8'h80);
    e = exp_out(147456);
    run_dot("neg_neg", e);
    accept("neg_neg", e);

    // -128 x 127 -> -146304 (0 with ReLU)
    fill(8'h80, 8'h7f);
    e = exp_out(-146304);
    run_dot("neg_pos", e);
    accept("neg_pos", e);

    // ramp 0..8 x 1 -> 36, address sequence checked inside run_dot
    for (int i = 0; i < N; i++) begin
      win_mem[i] = 8'(i);
      wgt_mem[i] = 8'd1;
    end
    e = exp_out(36);
    run_dot("ramp", e);

    // stall: ready low 5 cycles, start pulses ignored, output stable
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("stall_valid", 32'(result_valid), 32'd1);
      check("stall_result", 32'(result), 32'(e));
      check("stall_busy", 32'(busy), 32'd1);
      start = (i % 2 == 0);
    end
    @(negedge i_clk);
    check("stall_valid_end", 32'(result_valid), 32'd1);
    check("stall_result_end", 32'(result), 32'(e));

    // accept and start in the same cycle: 2 x -3 -> -54 (0 with ReLU)
    fill(8'd2, 8'hfd);
    e = exp_out(-54);
    result_ready = 1'b1;
    run_dot("b2b", e);
    accept("b2b", e);

    // reset during the 4th MAC cycle aborts the computation
    fill(8'd1, 8'd1);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      start = 1'b0;
    end
    check("abort_pre_state", 32'(dbg_state), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      check("abort_no_valid", 32'(result_valid), 32'd0);
    end

    // full computation after the abort
    e = exp_out(9);
    run_dot("post_abort", e);
    accept("post_abort", e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_mac_engine.md
WINDOW_MAC_ENGINE -- requirements
Module: window_mac_engine

Interface
REQ-001 SHALL have parameter WINDOW_ELEMNT_SIZE, default 8, width of one signed window element and one signed weight.
REQ-002 SHALL have parameter WINDOW_REG_SIZE, default 9, number of window elements per dot product.
REQ-003 SHALL have parameter ADDR_SIZE, default 4, width of the window and weight read addresses.
REQ-004 SHALL have parameter ACC_SIZE, default 20, width of the signed accumulator and result.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request one dot product over the current window.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port rd_addr, output, ADDR_SIZE bits: window element address, driven to the window register.
REQ-010 SHALL have port rd_data, input, WINDOW_ELEMNT_SIZE bits: window element, combinationally valid for rd_addr in the same cycle.
REQ-011 SHALL have port w_addr, output, ADDR_SIZE bits: kernel weight address, always equal to rd_addr.
REQ-012 SHALL have port w_data, input, WINDOW_ELEMNT_SIZE bits: kernel weight, combinationally valid for w_addr.
REQ-013 SHALL have port result, output, ACC_SIZE bits: signed dot-product result.
REQ-014 SHALL have port result_valid, output, 1 bit: result available.
REQ-015 SHALL have port result_ready, input, 1 bit: consumer accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, MAC, DONE.
REQ-017 IDLE: rd_addr=0; start=1 SHALL clear the accumulator, set index=0 and move to MAC.
REQ-018 MAC: each cycle SHALL drive rd_addr=index and add sign-extended rd_data*w_data (signed x signed) into the accumulator, then increment index.
REQ-019 MAC SHALL leave for DONE after the cycle with index=WINDOW_REG_SIZE-1, registering the final sum into result; exactly WINDOW_REG_SIZE MAC cycles.
REQ-020 Latency SHALL be: start sampled in cycle N; result_valid high from cycle N+WINDOW_REG_SIZE+1.
REQ-021 Accumulation SHALL wrap modulo 2^ACC_SIZE; no saturation; default widths cannot overflow.
REQ-022 DONE: result_valid and result SHALL hold stable until result_valid&&result_ready.
REQ-023 On handshake in DONE SHALL go to IDLE; if start is also high in that cycle, SHALL go directly to MAC with cleared accumulator.
REQ-024 start SHALL be ignored in MAC and in DONE without handshake.
REQ-025 result SHALL retain its last value in IDLE and MAC; result_valid low outside DONE.

Reset
REQ-026 i_rst SHALL force state=IDLE, index=0, accumulator=0, result=0, result_valid=0, busy=0, rd_addr=0.
REQ-027 i_rst SHALL take priority over start and the handshake and abort any in-progress MAC without producing a result.

Configuration
REQ-028 With macro WINDOW_MAC_RELU_EN defined, the value registered into result SHALL be 0 when the final sum is negative, else the sum.
REQ-029 Without WINDOW_MAC_RELU_EN, result SHALL be the raw signed sum.

Verification
REQ-030 All window elements 1, all weights 1, start pulse -> result=9, result_valid at cycle N+10, busy high cycles N+1..N+10.
REQ-031 Window all -128, weights all -128 -> result=147456; weights all 127 -> result=-146304 (without RELU), 0 (with WINDOW_MAC_RELU_EN).
REQ-032 Window 0..8 at addresses 0..8, weights 1 -> result=36; rd_addr sequence 0,1,..,8 in consecutive MAC cycles.
REQ-033 result_ready held low 5 cycles after result_valid -> result and result_valid stable; start pulses in that period ignored; accept then start same cycle -> next result_valid 10 cycles later.
REQ-034 i_rst asserted in 4th MAC cycle -> next cycle IDLE, busy=0, result=0, no result_valid; subsequent start yields correct full result.
